uart_rx_frame_controller: RTL
=============================

UART_RX_FRAME_CONTROLLER -- requirements
Module: uart_rx_frame_controller

Interface
REQ-001 Parameter PAYLOAD_LENGTH, default 784: payload bytes per frame (28x28 pixel image); legal range 1..2^ADDR_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 10: width of the frame-buffer address.
REQ-003 Parameter HEADER_BYTE, default 8'hAA: frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 32'd2_000_000: maximum idle clocks between bytes inside a frame (20 ms at 100 MHz).
REQ-005 clk  input  1  system clock, 100 MHz, all logic on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 rx_data  input  8  received byte from the UART receiver, valid only when rx_done_tick=1.
REQ-008 rx_done_tick  input  1  one-clock strobe: rx_data holds a new byte.
REQ-009 frame_ack  input  1  consumer (classifier) has read the buffer; releases it.
REQ-010 mem_we  output  1  frame-buffer write enable, one-clock pulse.
REQ-011 mem_addr  output  ADDR_WIDTH  frame-buffer write address.
REQ-012 mem_wdata  output  8  frame-buffer write data.
REQ-013 frame_ready  output  1  level: a complete, checksum-valid frame is in the buffer.
REQ-014 frame_error  output  1  one-clock pulse: frame aborted (bad checksum or timeout).
REQ-015 overrun  output  1  one-clock pulse: a byte arrived in READY and was dropped.
REQ-016 busy  output  1  high in PAYLOAD and CHECKSUM states.

Function
REQ-017 States: IDLE, PAYLOAD, CHECKSUM, READY; all outputs registered.
REQ-018 IDLE: on rx_done_tick with rx_data==HEADER_BYTE -> PAYLOAD, byte counter=0, sum=0, timeout counter=0; any other byte is discarded with no pulse.
REQ-019 PAYLOAD: each rx_done_tick -> next cycle mem_we=1, mem_addr=byte counter, mem_wdata=rx_data; sum += rx_data modulo 256; byte counter +1.
REQ-020 PAYLOAD: the byte accepted when byte counter == PAYLOAD_LENGTH-1 moves to CHECKSUM; the header value is not special inside a frame.
REQ-021 CHECKSUM: the next rx_done_tick is compared to the 8-bit sum; equal -> READY with frame_ready=1 the next cycle; unequal -> frame_error pulse, IDLE; no memory write.
REQ-022 Timeout counter: cleared on every rx_done_tick, increments each clock in PAYLOAD/CHECKSUM; on reaching TIMEOUT_CYCLES -> frame_error pulse, IDLE.
REQ-023 READY: frame_ready held high, memory not written; rx_done_tick -> overrun pulse, byte dropped (header included).
REQ-024 READY: frame_ack=1 -> frame_ready=0 next cycle, IDLE; frame_ack in any other state is ignored.
REQ-025 frame_ack and rx_done_tick in the same READY cycle: ack wins, byte dropped, overrun pulsed, state IDLE.
REQ-026 Byte-to-mem_we latency exactly 1 clock; mem_we never high for two consecutive cycles from a single rx_done_tick.
REQ-027 An aborted frame leaves partially written buffer contents; frame_ready is the sole validity indication.

Reset
REQ-028 reset=1 at a clock edge -> state IDLE, counters and sum 0, mem_we=0, mem_addr=0, mem_wdata=0, frame_ready=0, frame_error=0, overrun=0, busy=0.
REQ-029 Reset mid-frame or in READY discards the frame with no frame_error pulse; reset takes priority over all inputs in the same cycle.

Verification (PAYLOAD_LENGTH=4, TIMEOUT_CYCLES=100)
REQ-030 Bytes AA,01,02,03,04,0A -> mem writes addr0..3 = 01..04, frame_ready=1 one clock after the 0A strobe, no frame_error.
REQ-031 Bytes AA,01,02,03,04,0B -> four writes, frame_error single pulse, frame_ready stays 0, state IDLE.
REQ-032 Bytes 55,AA,AA,FF,00,01,AA -> 55 ignored; payload AA,FF,00,01 written; checksum AA (sum mod 256) -> frame_ready=1.
REQ-033 AA,01 then 100 idle clocks -> frame_error pulse, busy=0; later AA,05,05,05,05,14 completes normally from address 0.
REQ-034 Valid frame, then byte 33 while READY, same cycle as frame_ack -> overrun pulse, frame_ready=0, state IDLE, no mem_we.
REQ-035 reset asserted after 2 payload bytes -> all outputs 0 next cycle, no frame_error; subsequent valid frame writes from address 0.

Source files
------------

// File: rtl/uart_rx_frame_controller_if.sv
// Frame-controller bus: UART byte strobe, consumer ack, frame-buffer write
// port and status flags.
//   master : byte source / consumer side (drives rx_data, rx_done_tick, frame_ack)
//   slave  : frame controller side (drives mem_*, frame_ready, frame_error,
//            overrun, busy)
interface uart_rx_frame_controller_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_done_tick;
    logic                  frame_ack;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  frame_ready;
    logic                  frame_error;
    logic                  overrun;
    logic                  busy;

    modport master (
        output rx_data, rx_done_tick, frame_ack,
        input  mem_we, mem_addr, mem_wdata, frame_ready, frame_error, overrun, busy
    );

    modport slave (
        input  rx_data, rx_done_tick, frame_ack,
        output mem_we, mem_addr, mem_wdata, frame_ready, frame_error, overrun, busy
    );
endinterface

// File: rtl/uart_rx_frame_controller.sv
// UART receive frame controller.
// Frame format: HEADER_BYTE, PAYLOAD_LENGTH payload bytes, one checksum byte
// (8-bit sum of the payload). Payload bytes are written to a frame buffer at
// consecutive addresses from 0; a good checksum raises frame_ready until the
// consumer acknowledges.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave modport -- rx_data/rx_done_tick/frame_ack in;
//           mem_we/mem_addr/mem_wdata, frame_ready, frame_error (pulse),
//           overrun (pulse), busy out. All outputs registered.
module uart_rx_frame_controller #(
    parameter int          PAYLOAD_LENGTH = 784,
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [7:0]  HEADER_BYTE    = 8'hAA,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_rx_frame_controller_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECKSUM, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PAYLOAD_LENGTH - 1);
    localparam logic [31:0]           TO_LAST  = TIMEOUT_CYCLES - 32'd1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] byte_cnt;
    logic [7:0]            sum;
    logic [31:0]           to_cnt;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  frame_ready;
    logic                  frame_error;
    logic                  overrun;
    logic                  busy;

    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.frame_ready = frame_ready;
    assign bus.frame_error = frame_error;
    assign bus.overrun     = overrun;
    assign bus.busy        = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            sum         <= '0;
            to_cnt      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            frame_ready <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            mem_we      <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rx_done_tick && bus.rx_data == HEADER_BYTE) begin
                        state    <= PAYLOAD;
                        byte_cnt <= '0;
                        sum      <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                    end
                end

                PAYLOAD: begin
                    if (bus.rx_done_tick) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= byte_cnt;
                        mem_wdata <= bus.rx_data;
                        sum       <= sum + bus.rx_data;
                        to_cnt    <= '0;
                        if (byte_cnt == LAST_IDX) state <= CHECKSUM;
                        else                      byte_cnt <= byte_cnt + 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        // Counter would reach TIMEOUT_CYCLES this edge.
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end

                CHECKSUM: begin
                    if (bus.rx_done_tick) begin
                        to_cnt <= '0;
                        busy   <= 1'b0;
                        if (bus.rx_data == sum) begin
                            frame_ready <= 1'b1;
                            state       <= READY;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end

                READY: begin
                    // Buffer is owned by the consumer: any byte is dropped,
                    // even when the ack lands in the same cycle.
                    if (bus.rx_done_tick) overrun <= 1'b1;
                    if (bus.frame_ack) begin
                        frame_ready <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
